// File: rtl/multiword_adder_seq.sv
// Sequential multiword adder: adds two W = N*K bit operands one N-bit slice
// per cycle through a single N-bit adder, with valid/ready handshakes on both
// the request and the result side.
module multiword_adder_seq #(
    parameter int unsigned N = 4,
    parameter int unsigned K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] sum,
    output logic           cout,
    output logic           ovf,
    output logic           busy
);

    localparam int unsigned W  = N * K;
    // Wide enough to hold K, so the increment on the final slice cannot wrap.
    localparam int unsigned IW = (K > 1) ? $clog2(K + 1) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(K - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic [N:0]    slice_res;

    // The one N-bit adder: current slice of the latched operands plus carry.
    always_comb begin
        slice_a   = a_q[idx_q*N +: N];
        slice_b   = b_q[idx_q*N +: N];
        slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {{N{1'b0}}, carry_q};
    end

    // Next-state logic: accept in IDLE, one slice per cycle in ADD, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                sum_d[idx_q*N +: N] = slice_res[N-1:0];
                carry_d             = slice_res[N];
                idx_d               = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    cout_d  = slice_res[N];
                    // sum_d already carries the final slice, so its MSB is the result sign.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) & (sum_d[W-1] != a_q[W-1]);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StAdd);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
